alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequential front end for the 8-bit, 2-bit-selector ALU datapath. It collects X, Y and the operation selector as three bytes over one valid/ready input stream, then drives them onto the ALU operand ports. After a fixed settle interval it captures the ALU result and presents it on a valid/ready output stream. It replaces free-running operand sweeps with a handshaked, one-operation-at-a-time transaction interface.

## Interface
- WIDTH, 8: operand and result width
- SEL_W, 2: selector width, taken from in_data[SEL_W-1:0]
- SETTLE, 1: cycles allowed for ALU combinational settle; must be ≥1
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  operand/selector byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- alu_x  output  WIDTH  X operand to ALU
- alu_y  output  WIDTH  Y operand to ALU
- alu_sel  output  SEL_W  selector to ALU
- alu_result  input  WIDTH  ALU combinational output
- res_data  output  WIDTH  captured result
- res_valid  output  1  res_data is valid
- res_ready  input  1  consumer accepts res_data
- op_count  output  16  completed operations, wraps 0xFFFF→0x0000

## Operation
- States: S_X, S_Y, S_SEL, S_WAIT, S_OUT; reset state S_X.
- in_ready = 1 in S_X, S_Y and S_SEL only; it is decoded from the state register.
- Accept = in_valid & in_ready at a rising edge.
- S_X: on accept, alu_x ← in_data, go to S_Y.
- S_Y: on accept, alu_y ← in_data, go to S_SEL.
- S_SEL: on accept, alu_sel ← in_data[SEL_W-1:0] (upper bits ignored), cnt ← SETTLE-1, go to S_WAIT.
- S_WAIT: if cnt==0, res_data ← alu_result, res_valid ← 1, go to S_OUT. Otherwise cnt decrements. in_valid is ignored.
- S_OUT: res_valid held and res_data stable until res_ready. On the edge with res_valid & res_ready: res_valid ← 0, op_count increments, go to S_X.
- alu_x, alu_y and alu_sel hold their last loaded value until overwritten. They are not cleared between operations.
- No state waits on a timeout; the block stalls indefinitely on missing in_valid or res_ready.
- cnt width is clog2(SETTLE)+1.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - alu_x, alu_y, alu_sel, res_data = 0
  - res_valid = 0, op_count = 0, cnt = 0
  - state = S_X, so in_ready = 1 while rst is low
- Minimum operation: 3 accept edges + SETTLE edges + 1 handshake edge.
- Latency from the selector accept edge to res_valid high is SETTLE edges. With SETTLE=1, res_valid rises on the edge after selector accept.
- Back-to-back: the next X is accepted no earlier than the edge after the result handshake, because in_ready=0 in S_OUT.
- Gaps: in_valid low in any load state holds the state, and already-loaded operands are kept.
- Reset mid-operation (any state) discards partial operands and any pending result. op_count is not incremented for it.
- res_ready high while res_valid is low has no effect.
- op_count at 0xFFFF wraps to 0x0000 on the next completed handshake.

## Test plan
Bench ALU model for these scenarios: result = (x + y) mod 256 when sel=0, x & y when sel=1.

- Reset: assert rst mid-cycle without a clock edge → all outputs at reset values immediately, in_ready=1.
- Single operation, SETTLE=1, res_ready=1: stream 0x7F, 0x81, 0x00 → alu_x=0x7F, alu_y=0x81, res_data=0x00 one edge after selector accept, op_count=1.
- Selector masking and output stall: stream 0xF0, 0x3C, 0xFD (sel=1), hold res_ready=0 for 5 cycles → res_data=0x30 and res_valid stay stable, in_ready=0, then handshake → back to S_X.
- Input gaps: in_valid toggling 1,0,0,1,0,1 across the three bytes → correct operands loaded, no extra accepts.
- Reset mid-op: after X=0x11 and Y=0x22, pulse rst → state S_X, alu_x=alu_y=0, op_count unchanged at 0. Then a full operation 0x01, 0x01, 0x00 → res_data=0x02.
- SETTLE=3 and wrap: res_valid rises exactly 3 edges after selector accept. Force op_count to 0xFFFF via 65535 ops or a backdoor → the next handshake gives 0x0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Handshaked front end for a combinational ALU: collects X, Y and selector bytes,
// waits a fixed settle interval, then offers the captured result on a valid/ready stream.
module alu_op_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      op_count
);

  localparam int CNT_W = $clog2(SETTLE) + 1;

  typedef enum logic [2:0] {S_X, S_Y, S_SEL, S_WAIT, S_OUT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [SEL_W-1:0] r_alu_sel;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_valid;
  logic [15:0]      r_op_count;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_unused;

  assign w_in_ready = (r_state == S_X) || (r_state == S_Y) || (r_state == S_SEL);
  assign w_accept   = in_valid & w_in_ready;
  // Selector byte upper bits carry no meaning for the ALU.
  assign w_unused   = ^in_data[WIDTH-1:SEL_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_X;
      r_cnt       <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_alu_sel   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_X: begin
          if (w_accept) begin
            r_alu_x <= in_data;
            r_state <= S_Y;
          end
        end
        S_Y: begin
          if (w_accept) begin
            r_alu_y <= in_data;
            r_state <= S_SEL;
          end
        end
        S_SEL: begin
          if (w_accept) begin
            r_alu_sel <= in_data[SEL_W-1:0];
            r_cnt     <= CNT_W'(SETTLE - 1);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_res_data  <= alu_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= S_X;
          end
        end
        default: r_state <= S_X;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance with SETTLE=1 and one with SETTLE=3,
// shared stimulus steered by sel3, expected results queued per instance.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       res_ready;
  logic       sel3;

  logic       iv1, iv3, rr1, rr3, ir1, ir3, rv1, rv3;
  logic [7:0] ax1, ay1, ax3, ay3, ar1, ar3, rd1, rd3;
  logic [1:0] as1, as3;
  logic [15:0] oc1, oc3;

  logic       w_ir, w_rv;
  logic [7:0] w_rd, w_ax, w_ay;
  logic [1:0] w_as;
  logic [15:0] w_oc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  q1[$];
  logic [7:0]  q3[$];
  logic [15:0] exp_cnt1 = 16'd0;
  logic [15:0] exp_cnt3 = 16'd0;
  bit seen1 = 0;
  bit seen3 = 0;
  logic [7:0] mon_e;

  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] s);
    case (s)
      2'd0:    return 8'((int'(x) + int'(y)) % 256);
      2'd1:    return x & y;
      2'd2:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  assign iv1 = in_valid & ~sel3;
  assign iv3 = in_valid & sel3;
  assign rr1 = res_ready & ~sel3;
  assign rr3 = res_ready & sel3;
  assign ar1 = alu_f(ax1, ay1, as1);
  assign ar3 = alu_f(ax3, ay3, as3);
  assign w_ir = sel3 ? ir3 : ir1;
  assign w_rv = sel3 ? rv3 : rv1;
  assign w_rd = sel3 ? rd3 : rd1;
  assign w_ax = sel3 ? ax3 : ax1;
  assign w_ay = sel3 ? ay3 : ay1;
  assign w_as = sel3 ? as3 : as1;
  assign w_oc = sel3 ? oc3 : oc1;

  alu_op_sequencer #(.WIDTH(8), .SEL_W(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv1), .in_ready(ir1),
    .alu_x(ax1), .alu_y(ay1), .alu_sel(as1), .alu_result(ar1),
    .res_data(rd1), .res_valid(rv1), .res_ready(rr1), .op_count(oc1)
  );

  alu_op_sequencer #(.WIDTH(8), .SEL_W(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv3), .in_ready(ir3),
    .alu_x(ax3), .alu_y(ay3), .alu_sel(as3), .alu_result(ar3),
    .res_data(rd3), .res_valid(rv3), .res_ready(rr3), .op_count(oc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares each newly presented result against the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      seen1 = 0;
      seen3 = 0;
    end else begin
      if (rv1 && !seen1) begin
        seen1 = 1;
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb1_unexpected: got result 0x%0h with nothing expected", rd1);
        end else begin
          mon_e = q1.pop_front();
          chk("sb1_res_data", 32'(rd1), 32'(mon_e));
        end
      end else if (!rv1) begin
        seen1 = 0;
      end
      if (rv3 && !seen3) begin
        seen3 = 1;
        if (q3.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb3_unexpected: got result 0x%0h with nothing expected", rd3);
        end else begin
          mon_e = q3.pop_front();
          chk("sb3_res_data", 32'(rd3), 32'(mon_e));
        end
      end else if (!rv3) begin
        seen3 = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!w_ir && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic send_op(input bit d3, input logic [7:0] x, input logic [7:0] y, input logic [7:0] s,
                         input int gx, input int gy, input int gs, input int stall, input bit early_rr);
    logic [7:0] exp;
    int lat;
    exp = alu_f(x, y, s[1:0]);
    lat = d3 ? 3 : 1;
    sel3 = d3;
    if (early_rr) res_ready = 1'b1;
    send_byte(x, gx);
    send_byte(y, gy);
    if (d3) q3.push_back(exp); else q1.push_back(exp);
    send_byte(s, gs);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wait_in_ready", 32'(w_ir), 32'd0);
    chk("latency_e0", 32'(w_rv), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("latency", 32'(w_rv), (k == lat) ? 32'd1 : 32'd0);
    end
    if (!early_rr) begin
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", 32'(w_rv), 32'd1);
        chk("stall_data", 32'(w_rd), 32'(exp));
        chk("stall_in_ready", 32'(w_ir), 32'd0);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (d3) exp_cnt3 = exp_cnt3 + 16'd1; else exp_cnt1 = exp_cnt1 + 16'd1;
    chk("hs_valid_low", 32'(w_rv), 32'd0);
    chk("op_count", 32'(w_oc), d3 ? 32'(exp_cnt3) : 32'(exp_cnt1));
    chk("ready_after_hs", 32'(w_ir), 32'd1);
    chk("alu_x", 32'(w_ax), 32'(x));
    chk("alu_y", 32'(w_ay), 32'(y));
    chk("alu_sel", 32'(w_as), 32'(s[1:0]));
  endtask

  task automatic async_reset_and_check(input string tag);
    #2 rst = 1'b1;
    q1.delete();
    q3.delete();
    exp_cnt1 = 16'd0;
    exp_cnt3 = 16'd0;
    #1;
    chk({tag, "_in_ready1"},  32'(ir1), 32'd1);
    chk({tag, "_in_ready3"},  32'(ir3), 32'd1);
    chk({tag, "_alu_x"},      32'(w_ax), 32'd0);
    chk({tag, "_alu_y"},      32'(w_ay), 32'd0);
    chk({tag, "_alu_sel"},    32'(w_as), 32'd0);
    chk({tag, "_res_data"},   32'(w_rd), 32'd0);
    chk({tag, "_res_valid"},  32'(w_rv), 32'd0);
    chk({tag, "_op_count1"},  32'(oc1), 32'd0);
    chk({tag, "_op_count3"},  32'(oc3), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0; sel3 = 1'b0;
    @(negedge clk);
    async_reset_and_check("por");
    @(negedge clk);

    // Partial operation discarded by reset.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_alu_y", 32'(ay1), 32'h22);
    async_reset_and_check("midop");
    @(negedge clk);
    send_op(0, 8'h01, 8'h01, 8'h00, 0, 0, 0, 0, 0);

    send_op(0, 8'h7F, 8'h81, 8'h00, 0, 0, 0, 0, 1);
    send_op(0, 8'hF0, 8'h3C, 8'hFD, 0, 0, 0, 5, 0);
    send_op(0, 8'h5A, 8'hA5, 8'h02, 0, 2, 1, 0, 0);

    for (int i = 0; i < 20; i++)
      send_op(0, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Reset while a result is pending on the SETTLE=3 instance.
    sel3 = 1'b1;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    in_valid = 1'b0;
    async_reset_and_check("inwait");
    @(negedge clk);

    send_op(1, 8'h7F, 8'h81, 8'h00, 0, 0, 0, 0, 1);
    send_op(1, 8'hF0, 8'h3C, 8'hFD, 1, 0, 2, 2, 0);
    for (int i = 0; i < 10; i++)
      send_op(1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // op_count wrap: preload the counter while the instance idles in S_X.
    @(negedge clk);
    u_dut3.r_op_count = 16'hFFFF;
    exp_cnt3 = 16'hFFFF;
    send_op(1, 8'h80, 8'h80, 8'h00, 0, 0, 0, 1, 0);
    chk("wrap_zero", 32'(oc3), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
